// File: rtl/vload256.sv
// vload256 -- vector load sequencer for the 256-bit register file.
// A START command fetches eight consecutive 32-bit words, with one memory
// request outstanding at a time. The words are packed into little-endian
// lanes (the word at base+4k lands in lane k). The block then issues one
// write-back beat (WB/A3/WE).
// Optional feature: define VLOAD_RDEST_CHECK_EN to reject destination
// indices outside 0..5 with a one-cycle ERR pulse.
module vload256 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [4:0]        rdest_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [255:0]      wb_o,
  output logic [4:0]        a3_o,
  output logic              we_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e              state_q;
  logic [2:0]          k_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [255:0]        wb_q;
  logic [4:0]          a3_q;
  logic                busy_q;
  logic                mem_req_q;
  logic                we_q;
  logic                err_q;

  logic                reject_d;
  logic                accept_d;
  logic [ADDR_W-1:0]   addr_inc_d;

`ifdef VLOAD_RDEST_CHECK_EN
  // The register file only implements indices 0..5.
  function automatic logic rdest_bad(input logic [4:0] r);
    return (r[4:3] != 2'b00) || (r[2:0] >= 3'd6);
  endfunction

  assign reject_d = start_i && rdest_bad(rdest_i);
`else
  assign reject_d = 1'b0;
`endif

  assign accept_d   = start_i && !reject_d;
  // The address advances by one word and wraps modulo 2^ADDR_W.
  assign addr_inc_d = addr_q + ADDR_W'(4);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      addr_q    <= '0;
      wb_q      <= '0;
      a3_q      <= 5'd0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      // The reject pulse only comes from a START seen while idle.
      err_q <= (state_q == S_IDLE) && reject_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            // The low two address bits are ignored, so the first word is aligned.
            addr_q    <= base_i & ~ADDR_W'(3);
            a3_q      <= rdest_i;
            k_q       <= 3'd0;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // addr_q does not change here, so the address is stable until the grant.
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            wb_q[{k_q, 5'b00000} +: 32] <= mem_rdata_i;
            if (k_q == 3'd7) begin
              we_q    <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              k_q       <= k_q + 3'd1;
              addr_q    <= addr_inc_d;
              mem_req_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_WRITE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = addr_q;
  assign wb_o       = wb_q;
  assign a3_o       = a3_q;
  assign we_o       = we_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_vload256.sv
// Bench for vload256. A behavioural model predicts the address sequence,
// the assembled vector and the cycle of the write beat. The model works
// from the base address, the per-word stall counts and the returned data.
module tb_vload256;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [31:0]  base_i;
  logic [4:0]   rdest_i;
  logic         busy_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic [255:0] wb_o;
  logic [4:0]   a3_o;
  logic         we_o;
  logic         err_o;

  int n_cmp = 0;
  int n_err = 0;

  int cyc_g  = 0;
  int we_cnt = 0;
  int we_cyc = 0;

  int          gdel[8];
  int          rdel[8];
  logic [31:0] wdat[8];

  vload256 #(.ADDR_W(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_i       (base_i),
    .rdest_i      (rdest_i),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_o         (wb_o),
    .a3_o         (a3_o),
    .we_o         (we_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_g <= cyc_g + 1;

  always @(negedge clk_i) begin
    if (we_o) begin
      we_cnt <= we_cnt + 1;
      we_cyc <= cyc_g;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_plain(input int mode);
    for (int k = 0; k < 8; k++) begin
      gdel[k] = 0;
      rdel[k] = 0;
      if (mode == 0) wdat[k] = 32'h1111_1111 * (k + 1);
      else           wdat[k] = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_req"},  mem_req_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wb"},   wb_o, 0);
    check({tag, "_a3"},   a3_o, 0);
    check({tag, "_we"},   we_o, 0);
    check({tag, "_err"},  err_o, 0);
  endtask

  // One complete load driven cycle by cycle. The expectations come from the
  // aligned base, the data words and the total stall count.
  task automatic run_load(input logic [31:0] base, input logic [4:0] rd,
                          input int abort_k, input bit pstart, input bit spur);
    logic [31:0]  ab;
    logic [31:0]  ea;
    logic [255:0] exp_wb;
    int           stalls;
    int           we0;
    int           sc;
    ab     = base & 32'hFFFF_FFFC;
    exp_wb = '0;
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      exp_wb[32*k +: 32] = wdat[k];
      stalls += gdel[k] + rdel[k];
    end
    we0 = we_cnt;
    start_i = 1'b1; base_i = base; rdest_i = rd;
    step();
    start_i = 1'b0; base_i = $urandom; rdest_i = 5'($urandom);
    sc = cyc_g;
    check("busy_after_start", busy_o, 1);
    for (int k = 0; k < 8; k++) begin
      ea = ab + 32'(4 * k);
      for (int s = 0; s < gdel[k]; s++) begin
        check("req_in_stall", mem_req_o, 1);
        check("addr_in_stall", mem_addr_o, ea);
        mem_gnt_i = 1'b0;
        if (spur && s == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; end
        if (pstart) begin start_i = 1'b1; base_i = $urandom; end
        step();
        mem_rvalid_i = 1'b0; start_i = 1'b0;
      end
      check("req_at_grant", mem_req_o, 1);
      check("addr_at_grant", mem_addr_o, ea);
      mem_gnt_i = 1'b1;
      if (pstart) begin start_i = 1'b1; base_i = $urandom; end
      step();
      mem_gnt_i = 1'b0; start_i = 1'b0;
      for (int s = 0; s < rdel[k]; s++) begin
        check("req_low_in_wait", mem_req_o, 0);
        if (pstart) start_i = 1'b1;
        step();
        start_i = 1'b0;
      end
      mem_rvalid_i = 1'b1; mem_rdata_i = wdat[k];
      step();
      mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (k == abort_k) begin
        rst_ni = 1'b0;
        #1;
        check_all_zero("abort");
        for (int s = 0; s < 2; s++) begin
          mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1;
          step();
        end
        rst_ni = 1'b1;
        step();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
        step(); step();
        check("abort_busy", busy_o, 0);
        check("abort_req", mem_req_o, 0);
        check("abort_no_we", we_cnt - we0, 0);
        return;
      end
    end
    check("we_high", we_o, 1);
    check("a3", a3_o, rd);
    check("wb", wb_o, exp_wb);
    check("busy_in_write", busy_o, 1);
    step();
    check("we_low_after", we_o, 0);
    check("busy_low_after", busy_o, 0);
    check("wb_held", wb_o, exp_wb);
    check("we_count", we_cnt - we0, 1);
    check("we_cycle", we_cyc - sc + 1, 17 + stalls);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; base_i = '0; rdest_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step(); step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // Basic load
    set_plain(0);
    run_load(32'h0000_0100, 5'd2, -1, 1'b0, 1'b0);
    check("basic_wb_const", wb_o,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

    // Grant and response stalls
    set_plain(0);
    gdel[0] = 3; rdel[5] = 4;
    run_load(32'h0000_0100, 5'd2, -1, 1'b0, 1'b0);

    // START while busy and a spurious RVALID during REQ
    set_plain(1);
    gdel[2] = 1; gdel[6] = 2; rdel[3] = 1;
    run_load(32'h0000_2000, 5'd4, -1, 1'b1, 1'b1);

    // Address wrap and alignment
    set_plain(1);
    run_load(32'hFFFF_FFF3, 5'd1, -1, 1'b0, 1'b0);

    // Reset after word 3, then a normal load
    set_plain(1);
    run_load(32'h0000_0400, 5'd3, 3, 1'b0, 1'b0);
    set_plain(0);
    run_load(32'h0000_0100, 5'd2, -1, 1'b0, 1'b0);

`ifdef VLOAD_RDEST_CHECK_EN
    begin
      int we0;
      we0 = we_cnt;
      start_i = 1'b1; base_i = 32'h0000_0800; rdest_i = 5'd6;
      step();
      start_i = 1'b0;
      check("rej_err", err_o, 1);
      check("rej_busy", busy_o, 0);
      check("rej_req", mem_req_o, 0);
      step();
      check("rej_err_one_cycle", err_o, 0);
      check("rej_req_later", mem_req_o, 0);
      step(); step();
      check("rej_no_we", we_cnt - we0, 0);
    end
    set_plain(1);
    run_load(32'h0000_0800, 5'd5, -1, 1'b0, 1'b0);
`else
    set_plain(1);
    start_i = 1'b0;
    run_load(32'h0000_0800, 5'd6, -1, 1'b0, 1'b0);
    check("err_tied_low", err_o, 0);
`endif

    // Randomized loads
    for (int t = 0; t < 8; t++) begin
      logic [4:0] rd;
      for (int k = 0; k < 8; k++) begin
        gdel[k] = $urandom_range(0, 3);
        rdel[k] = $urandom_range(0, 3);
        wdat[k] = $urandom;
      end
`ifdef VLOAD_RDEST_CHECK_EN
      rd = 5'($urandom_range(0, 5));
`else
      rd = 5'($urandom_range(0, 31));
`endif
      run_load($urandom, rd, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rand_err_low", err_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
